// File: rtl/score_life_keeper_pkg.sv
// Shared types and constants for the score/life keeper: BCD score type,
// score FSM states and a capture-time digit clamp.
package score_pkg;

  typedef logic [23:0] bcd6_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIGIT,
    COMMIT
  } score_state_e;

  localparam bcd6_t BCD_MAX    = 24'h999999;
  localparam int    NUM_DIGITS = 6;

  // Any nibble above 9 is not a legal BCD digit; treat it as 9.
  function automatic bcd6_t clampBcd(input bcd6_t v);
    bcd6_t r;
    r = v;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_life_keeper_bcd_digit_alu.sv
// Single BCD digit adder/subtractor with carry (add) or borrow (sub) chaining.
module bcd_digit_alu (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  input  logic       sub_i,
  output logic [3:0] res_o,
  output logic       cout_o
);

  logic [4:0] sum5;
  logic [4:0] need5;

  // Add wraps above 9 with a carry; subtract borrows ten when a < b + borrow.
  always_comb begin
    sum5   = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    need5  = {1'b0, b_i} + {4'b0000, cin_i};
    res_o  = 4'd0;
    cout_o = 1'b0;
    if (!sub_i) begin
      if (sum5 > 5'd9) begin
        res_o  = 4'(sum5 - 5'd10);
        cout_o = 1'b1;
      end else begin
        res_o = sum5[3:0];
      end
    end else begin
      if ({1'b0, a_i} >= need5) begin
        res_o = 4'({1'b0, a_i} - need5);
      end else begin
        res_o  = 4'({1'b0, a_i} + 5'd10 - need5);
        cout_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_life_keeper.sv
// Game state keeper: digit-serial BCD score with one-deep add/sub request
// buffers, saturating life counter with game-over latch, and a frame-based
// bonus countdown timer.
module score_life_keeper
  import score_pkg::*;
#(
  parameter int LIVES_INIT = 3,
  parameter int LIVES_MAX  = 7,
  parameter int TIME_W     = 11
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              gameRestart,
  input  logic              enableAddScore,
  input  logic              enableRemoveScore,
  input  logic [23:0]       scoreAmount,
  input  logic              enableAddLife,
  input  logic              enableRemoveLife,
  input  logic [2:0]        lifeAmount,
  input  logic              requestTime,
  input  logic [TIME_W-1:0] timeLenReq,
  output logic [23:0]       score,
  output logic [2:0]        lives,
  output logic              gameOver,
  output logic              scoreBusy,
  output logic              scoreDropped,
  output logic              bonusActive,
  output logic [TIME_W-1:0] bonusFramesLeft
);

  localparam logic signed [4:0] LivesMaxS  = 5'(LIVES_MAX);
  localparam logic [2:0]        LivesInitV = 3'(LIVES_INIT);

  score_state_e      state_q;
  logic [2:0]        idx_q;
  bcd6_t             work_q;
  bcd6_t             opnd_q;
  logic              isSub_q;
  logic              carry_q;
  bcd6_t             score_q;
  logic              addPend_q;
  logic              subPend_q;
  bcd6_t             addAmt_q;
  bcd6_t             subAmt_q;
  logic              dropped_q;
  logic [2:0]        lives_q;
  logic [2:0]        lives_d;
  logic              gameOver_q;
  logic              gameOver_d;
  logic [TIME_W-1:0] bonus_q;
  logic [TIME_W-1:0] bonus_d;
  logic signed [4:0] livesSum;

  logic [3:0] aluRes;
  logic       aluCout;
  logic       clearAdd;
  logic       clearSub;
  logic       takeAddReq;
  logic       takeSubReq;

  bcd_digit_alu uAlu (
    .a_i   (work_q[3:0]),
    .b_i   (opnd_q[3:0]),
    .cin_i (carry_q),
    .sub_i (isSub_q),
    .res_o (aluRes),
    .cout_o(aluCout)
  );

  // A latch being emptied by LOAD on this edge can accept a new request.
  assign clearAdd   = (state_q == LOAD) && !isSub_q;
  assign clearSub   = (state_q == LOAD) &&  isSub_q;
  assign takeAddReq = enableAddScore    && !gameOver_q;
  assign takeSubReq = enableRemoveScore && !gameOver_q;

  // Score FSM with request capture; digits rotate through the working register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      work_q    <= '0;
      opnd_q    <= '0;
      isSub_q   <= 1'b0;
      carry_q   <= 1'b0;
      score_q   <= '0;
      addPend_q <= 1'b0;
      subPend_q <= 1'b0;
      addAmt_q  <= '0;
      subAmt_q  <= '0;
      dropped_q <= 1'b0;
    end else if (gameRestart) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      work_q    <= '0;
      opnd_q    <= '0;
      isSub_q   <= 1'b0;
      carry_q   <= 1'b0;
      score_q   <= '0;
      addPend_q <= 1'b0;
      subPend_q <= 1'b0;
      addAmt_q  <= '0;
      subAmt_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (clearAdd) addPend_q <= 1'b0;
      if (clearSub) subPend_q <= 1'b0;
      if (takeAddReq) begin
        if (addPend_q && !clearAdd) begin
          dropped_q <= 1'b1;
        end else begin
          addPend_q <= 1'b1;
          addAmt_q  <= clampBcd(scoreAmount);
        end
      end
      if (takeSubReq) begin
        if (subPend_q && !clearSub) begin
          dropped_q <= 1'b1;
        end else begin
          subPend_q <= 1'b1;
          subAmt_q  <= clampBcd(scoreAmount);
        end
      end
      case (state_q)
        IDLE: begin
          if (addPend_q) begin
            isSub_q <= 1'b0;
            state_q <= LOAD;
          end else if (subPend_q) begin
            isSub_q <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          work_q  <= score_q;
          opnd_q  <= isSub_q ? subAmt_q : addAmt_q;
          carry_q <= 1'b0;
          idx_q   <= 3'd0;
          state_q <= DIGIT;
        end
        DIGIT: begin
          work_q  <= {aluRes, work_q[23:4]};
          opnd_q  <= {4'h0, opnd_q[23:4]};
          carry_q <= aluCout;
          if (idx_q == 3'(NUM_DIGITS - 1)) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        COMMIT: begin
          if (carry_q) begin
            score_q <= isSub_q ? '0 : BCD_MAX;
          end else begin
            score_q <= work_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next life count: net delta in signed 5 bits, clamped to 0..LIVES_MAX.
  always_comb begin
    livesSum = $signed({2'b00, lives_q});
    if (enableAddLife && !gameOver_q) livesSum = livesSum + $signed({2'b00, lifeAmount});
    if (enableRemoveLife && !gameOver_q) livesSum = livesSum - $signed({2'b00, lifeAmount});
    if (livesSum < 5'sd0) begin
      lives_d = 3'd0;
    end else if (livesSum > LivesMaxS) begin
      lives_d = LivesMaxS[2:0];
    end else begin
      lives_d = livesSum[2:0];
    end
    gameOver_d = gameOver_q | (lives_d == 3'd0);
  end

  // Bonus timer next value: a request loads the larger length, else frames count down.
  always_comb begin
    bonus_d = bonus_q;
    if (requestTime && !gameOver_q && (timeLenReq != '0)) begin
      bonus_d = (timeLenReq > bonus_q) ? timeLenReq : bonus_q;
    end else if (startOfFrame && (bonus_q != '0)) begin
      bonus_d = bonus_q - TIME_W'(1);
    end
  end

  // Life, game-over and bonus state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lives_q    <= LivesInitV;
      gameOver_q <= 1'b0;
      bonus_q    <= '0;
    end else if (gameRestart) begin
      lives_q    <= LivesInitV;
      gameOver_q <= 1'b0;
      bonus_q    <= '0;
    end else begin
      lives_q    <= lives_d;
      gameOver_q <= gameOver_d;
      bonus_q    <= bonus_d;
    end
  end

  assign score           = score_q;
  assign lives           = lives_q;
  assign gameOver        = gameOver_q;
  assign scoreBusy       = (state_q != IDLE) | addPend_q | subPend_q;
  assign scoreDropped    = dropped_q;
  assign bonusActive     = (bonus_q != '0);
  assign bonusFramesLeft = bonus_q;

endmodule

// File: tb/tb_score_life_keeper.sv
// Directed self-checking bench for score_life_keeper.
module tb_score_life_keeper;

  localparam int TIME_W = 11;

  logic              clk;
  logic              resetN;
  logic              startOfFrame;
  logic              gameRestart;
  logic              enableAddScore;
  logic              enableRemoveScore;
  logic [23:0]       scoreAmount;
  logic              enableAddLife;
  logic              enableRemoveLife;
  logic [2:0]        lifeAmount;
  logic              requestTime;
  logic [TIME_W-1:0] timeLenReq;
  logic [23:0]       score;
  logic [2:0]        lives;
  logic              gameOver;
  logic              scoreBusy;
  logic              scoreDropped;
  logic              bonusActive;
  logic [TIME_W-1:0] bonusFramesLeft;

  int assertCount = 0;
  int failCount   = 0;

  score_life_keeper #(
    .LIVES_INIT(3),
    .LIVES_MAX (7),
    .TIME_W    (TIME_W)
  ) dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .gameRestart      (gameRestart),
    .enableAddScore   (enableAddScore),
    .enableRemoveScore(enableRemoveScore),
    .scoreAmount      (scoreAmount),
    .enableAddLife    (enableAddLife),
    .enableRemoveLife (enableRemoveLife),
    .lifeAmount       (lifeAmount),
    .requestTime      (requestTime),
    .timeLenReq       (timeLenReq),
    .score            (score),
    .lives            (lives),
    .gameOver         (gameOver),
    .scoreBusy        (scoreBusy),
    .scoreDropped     (scoreDropped),
    .bonusActive      (bonusActive),
    .bonusFramesLeft  (bonusFramesLeft)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doRestart();
    gameRestart = 1'b1;
    tick();
    gameRestart = 1'b0;
  endtask

  task automatic pulseAdd(input logic [23:0] amt);
    scoreAmount    = amt;
    enableAddScore = 1'b1;
    tick();
    enableAddScore = 1'b0;
  endtask

  task automatic pulseSub(input logic [23:0] amt);
    scoreAmount       = amt;
    enableRemoveScore = 1'b1;
    tick();
    enableRemoveScore = 1'b0;
  endtask

  task automatic pulseLife(input logic add, input logic rem, input logic [2:0] amt);
    lifeAmount       = amt;
    enableAddLife    = add;
    enableRemoveLife = rem;
    tick();
    enableAddLife    = 1'b0;
    enableRemoveLife = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40; i++) begin
      if (!scoreBusy) break;
      tick();
    end
    assertCount++;
    if (scoreBusy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL wait_idle: scoreBusy=%0b after 40 cycles, required 0", scoreBusy);
    end
  endtask

  task automatic setScore(input logic [23:0] v);
    doRestart();
    if (v != 24'h0) begin
      pulseAdd(v);
      waitIdle();
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #12;
    assertCount++;
    if (score !== 24'h0 || lives !== 3'd3 || gameOver !== 1'b0 || scoreBusy !== 1'b0 ||
        scoreDropped !== 1'b0 || bonusFramesLeft !== '0 || bonusActive !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_state: score=%h lives=%0d go=%0b busy=%0b drop=%0b bonus=%0d act=%0b, required 0/3/0/0/0/0/0",
               score, lives, gameOver, scoreBusy, scoreDropped, bonusFramesLeft, bonusActive);
    end
    #10;
    resetN = 1'b1;
    tick();
    assertCount++;
    if (score !== 24'h0 || lives !== 3'd3 || scoreBusy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL post_reset: score=%h lives=%0d busy=%0b, required 0/3/0", score, lives, scoreBusy);
    end
  endtask

  task automatic test_latency();
    doRestart();
    pulseAdd(24'h000040);
    assertCount++;
    if (scoreBusy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL latency_busy_e0: scoreBusy=%0b, required 1", scoreBusy);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      assertCount++;
      if (scoreBusy !== 1'b1 || score !== 24'h0) begin
        failCount++;
        $display("[TB] FAIL latency_e%0d: busy=%0b score=%h, required busy=1 score=000000", k, scoreBusy, score);
      end
    end
    tick();
    assertCount++;
    if (score !== 24'h000040) begin
      failCount++;
      $display("[TB] FAIL latency_e9_score: got %h, required 000040", score);
    end
    assertCount++;
    if (scoreBusy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL latency_e9_busy: got %0b, required 0", scoreBusy);
    end
  endtask

  task automatic test_carry();
    setScore(24'h000095);
    pulseAdd(24'h000160);
    waitIdle();
    assertCount++;
    if (score !== 24'h000255) begin
      failCount++;
      $display("[TB] FAIL carry_chain: got %h, required 000255", score);
    end
    setScore(24'h999990);
    pulseAdd(24'h000020);
    waitIdle();
    assertCount++;
    if (score !== 24'h999999) begin
      failCount++;
      $display("[TB] FAIL add_saturate: got %h, required 999999", score);
    end
  endtask

  task automatic test_subtract();
    setScore(24'h000255);
    pulseSub(24'h000160);
    waitIdle();
    assertCount++;
    if (score !== 24'h000095) begin
      failCount++;
      $display("[TB] FAIL borrow_chain: got %h, required 000095", score);
    end
    setScore(24'h000030);
    pulseSub(24'h000040);
    waitIdle();
    assertCount++;
    if (score !== 24'h000000) begin
      failCount++;
      $display("[TB] FAIL sub_floor: got %h, required 000000", score);
    end
  endtask

  task automatic test_clamp();
    setScore(24'h000100);
    pulseAdd(24'h00000F);
    waitIdle();
    assertCount++;
    if (score !== 24'h000109) begin
      failCount++;
      $display("[TB] FAIL digit_clamp: got %h, required 000109", score);
    end
  endtask

  task automatic test_add_sub_same();
    setScore(24'h000050);
    scoreAmount       = 24'h000010;
    enableAddScore    = 1'b1;
    enableRemoveScore = 1'b1;
    tick();
    enableAddScore    = 1'b0;
    enableRemoveScore = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    assertCount++;
    if (score !== 24'h000060) begin
      failCount++;
      $display("[TB] FAIL same_cycle_add_first: got %h, required 000060", score);
    end
    waitIdle();
    assertCount++;
    if (score !== 24'h000050) begin
      failCount++;
      $display("[TB] FAIL same_cycle_final: got %h, required 000050", score);
    end
  endtask

  task automatic test_back_to_back();
    setScore(24'h000100);
    pulseAdd(24'h000025);
    tick();
    pulseAdd(24'h000025);
    assertCount++;
    if (scoreDropped !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_second_pended: scoreDropped=%0b, required 0", scoreDropped);
    end
    tick();
    pulseAdd(24'h000025);
    assertCount++;
    if (scoreDropped !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL b2b_third_dropped: scoreDropped=%0b, required 1", scoreDropped);
    end
    waitIdle();
    assertCount++;
    if (score !== 24'h000150) begin
      failCount++;
      $display("[TB] FAIL b2b_final: got %h, required 000150", score);
    end
    doRestart();
    assertCount++;
    if (scoreDropped !== 1'b0 || score !== 24'h0) begin
      failCount++;
      $display("[TB] FAIL restart_clears_drop: drop=%0b score=%h, required 0/000000", scoreDropped, score);
    end
  endtask

  task automatic test_lives();
    doRestart();
    pulseLife(1'b0, 1'b1, 3'd1);
    assertCount++;
    if (lives !== 3'd2 || gameOver !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL lives_rem1: lives=%0d go=%0b, required 2/0", lives, gameOver);
    end
    pulseLife(1'b0, 1'b1, 3'd1);
    assertCount++;
    if (lives !== 3'd1 || gameOver !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL lives_rem2: lives=%0d go=%0b, required 1/0", lives, gameOver);
    end
    pulseLife(1'b0, 1'b1, 3'd1);
    assertCount++;
    if (lives !== 3'd0 || gameOver !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL lives_rem3: lives=%0d go=%0b, required 0/1", lives, gameOver);
    end
    pulseLife(1'b1, 1'b0, 3'd2);
    assertCount++;
    if (lives !== 3'd0 || gameOver !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL gameover_ignores_life: lives=%0d go=%0b, required 0/1", lives, gameOver);
    end
    pulseAdd(24'h000005);
    tick();
    assertCount++;
    if (scoreBusy !== 1'b0 || scoreDropped !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL gameover_ignores_score: busy=%0b drop=%0b, required 0/0", scoreBusy, scoreDropped);
    end
    requestTime = 1'b1;
    timeLenReq  = 11'd20;
    tick();
    requestTime = 1'b0;
    assertCount++;
    if (bonusFramesLeft !== 11'd0) begin
      failCount++;
      $display("[TB] FAIL gameover_ignores_time: got %0d, required 0", bonusFramesLeft);
    end
    doRestart();
    assertCount++;
    if (lives !== 3'd3 || gameOver !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL lives_restart: lives=%0d go=%0b, required 3/0", lives, gameOver);
    end
    pulseLife(1'b1, 1'b0, 3'd7);
    assertCount++;
    if (lives !== 3'd7) begin
      failCount++;
      $display("[TB] FAIL lives_saturate: got %0d, required 7", lives);
    end
    pulseLife(1'b1, 1'b1, 3'd2);
    assertCount++;
    if (lives !== 3'd7) begin
      failCount++;
      $display("[TB] FAIL lives_net_zero: got %0d, required 7", lives);
    end
    pulseLife(1'b0, 1'b1, 3'd3);
    assertCount++;
    if (lives !== 3'd4) begin
      failCount++;
      $display("[TB] FAIL lives_rem3_from7: got %0d, required 4", lives);
    end
    pulseLife(1'b0, 1'b1, 3'd6);
    assertCount++;
    if (lives !== 3'd0 || gameOver !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL lives_floor: lives=%0d go=%0b, required 0/1", lives, gameOver);
    end
    doRestart();
  endtask

  task automatic test_bonus();
    doRestart();
    requestTime = 1'b1;
    timeLenReq  = 11'd60;
    tick();
    requestTime = 1'b0;
    assertCount++;
    if (bonusFramesLeft !== 11'd60 || bonusActive !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL bonus_load: left=%0d act=%0b, required 60/1", bonusFramesLeft, bonusActive);
    end
    for (int k = 0; k < 10; k++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
    assertCount++;
    if (bonusFramesLeft !== 11'd50) begin
      failCount++;
      $display("[TB] FAIL bonus_countdown: got %0d, required 50", bonusFramesLeft);
    end
    requestTime = 1'b1;
    timeLenReq  = 11'd10;
    tick();
    requestTime = 1'b0;
    assertCount++;
    if (bonusFramesLeft !== 11'd50) begin
      failCount++;
      $display("[TB] FAIL bonus_keep_max: got %0d, required 50", bonusFramesLeft);
    end
    requestTime  = 1'b1;
    startOfFrame = 1'b1;
    timeLenReq   = 11'd40;
    tick();
    requestTime  = 1'b0;
    startOfFrame = 1'b0;
    assertCount++;
    if (bonusFramesLeft !== 11'd50) begin
      failCount++;
      $display("[TB] FAIL bonus_load_wins: got %0d, required 50", bonusFramesLeft);
    end
    requestTime = 1'b1;
    timeLenReq  = 11'd70;
    tick();
    requestTime = 1'b0;
    assertCount++;
    if (bonusFramesLeft !== 11'd70) begin
      failCount++;
      $display("[TB] FAIL bonus_extend: got %0d, required 70", bonusFramesLeft);
    end
    doRestart();
    requestTime = 1'b1;
    timeLenReq  = 11'd3;
    tick();
    requestTime = 1'b0;
    for (int k = 0; k < 4; k++) begin
      startOfFrame = 1'b1;
      tick();
    end
    startOfFrame = 1'b0;
    assertCount++;
    if (bonusFramesLeft !== 11'd0 || bonusActive !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL bonus_expire: left=%0d act=%0b, required 0/0", bonusFramesLeft, bonusActive);
    end
  endtask

  initial begin
    resetN            = 1'b0;
    startOfFrame      = 1'b0;
    gameRestart       = 1'b0;
    enableAddScore    = 1'b0;
    enableRemoveScore = 1'b0;
    scoreAmount       = 24'h0;
    enableAddLife     = 1'b0;
    enableRemoveLife  = 1'b0;
    lifeAmount        = 3'd0;
    requestTime       = 1'b0;
    timeLenReq        = '0;

    $display("[TB] starting score_life_keeper bench");
    test_reset();
    test_latency();
    test_carry();
    test_subtract();
    test_clamp();
    test_add_sub_same();
    test_back_to_back();
    test_lives();
    test_bonus();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/score_life_keeper.md
Name: score_life_keeper

Overview:
- Consumes the per-cycle collision/event pulses from game_controller: score add/remove, life add/remove, time-bonus request.
- Maintains the game state registers: 6-digit BCD score, life count, game-over flag and bonus countdown timer.
- Score arithmetic is digit-serial, one BCD digit per clk, with a one-deep request buffer per operation.
- Outputs feed the score/life display and the game FSM.

Parameters:
LIVES_INIT, 3, life count after reset/restart (1..LIVES_MAX)
LIVES_MAX, 7, life saturation ceiling (fits 3 bits)
TIME_W, 11, width of bonus frame counter

Ports:
clk  in  1  system clock
resetN  in  1  async active-low reset
startOfFrame  in  1  one-clk pulse per frame
gameRestart  in  1  sync restart; same effect as reset
enableAddScore  in  1  one-clk pulse: add scoreAmount
enableRemoveScore  in  1  one-clk pulse: subtract scoreAmount
scoreAmount  in  24  packed BCD; digit k in bits [4k+3:4k], digit 0 = units
enableAddLife  in  1  one-clk pulse: add lifeAmount
enableRemoveLife  in  1  one-clk pulse: subtract lifeAmount
lifeAmount  in  3  life delta
requestTime  in  1  one-clk pulse: bonus request
timeLenReq  in  TIME_W  bonus length in frames
score  out  24  committed BCD score
lives  out  3  current lives
gameOver  out  1  level; lives reached 0
scoreBusy  out  1  score op in flight or pending
scoreDropped  out  1  sticky; a score request was lost
bonusActive  out  1  bonusFramesLeft != 0
bonusFramesLeft  out  TIME_W  remaining bonus frames

Behaviour:
- Reset (async) and gameRestart (sync) set the same values:
  - score=0, lives=LIVES_INIT, gameOver=0, scoreDropped=0, bonusFramesLeft=0.
  - Pending latches cleared; FSM to IDLE. gameRestart aborts any in-flight op.
- Request capture:
  - On an enable pulse, amount is latched into addPend/subPend, each with its own amount register.
  - If the matching latch is already full, the request is dropped and scoreDropped=1.
  - Digits >9 in scoreAmount are clamped to 9 at capture.
- Score FSM: IDLE -> LOAD -> DIGIT (6 cycles, idx 0..5) -> COMMIT -> IDLE.
  - IDLE: if addPend, take add; else if subPend, take sub. Add has priority when both are set.
  - LOAD: copy score to working register; clear carry/borrow; clear the selected pend latch.
  - DIGIT add: sum = a+b+c; if sum>9, digit = sum-10 and c=1.
  - DIGIT sub: d = a-b-borrow; if d<0, digit = d+10 and borrow=1.
  - COMMIT: add with final carry -> score=999999 (saturate). Sub with final borrow -> score=0 (floor). Otherwise score = working register.
- Latency: an enable sampled at edge E0 with FSM idle gives score updated at edge E9. Score never shows partial digits.
- scoreBusy = (state!=IDLE) | addPend | subPend.
- Lives: single-cycle update.
  - new = lives + (addLife ? lifeAmount : 0) - (remLife ? lifeAmount : 0).
  - Computed in 5-bit signed, then clamped to 0..LIVES_MAX.
  - Simultaneous add and remove nets out.
- gameOver:
  - Set on the edge where lives becomes 0; holds until reset/restart.
  - While gameOver=1, all score/life/time requests are ignored. Ignored requests do not set scoreDropped; an in-flight op still completes.
- Bonus timer:
  - requestTime with timeLenReq!=0 loads max(bonusFramesLeft, timeLenReq).
  - startOfFrame decrements when nonzero; stops at 0.
  - requestTime and startOfFrame on the same cycle: load wins, no decrement that cycle.

Decomposition:
- Package score_pkg:
  - typedef bcd6_t (24-bit packed) and score FSM enum {IDLE, LOAD, DIGIT, COMMIT}.
  - Constants BCD_MAX=24'h999999, NUM_DIGITS=6.
- One sub-module bcd_digit_alu: comb single-digit add/sub with carry/borrow in/out, instantiated once and reused per cycle.

Test Plan:
- Reset, then enableAddScore with scoreAmount=24'h000040 -> score=24'h000040 exactly 9 clks later; scoreBusy high for edges E0..E8.
- score=24'h000095 plus add 24'h000160 -> 24'h000255 (carry chain); score=24'h999990 plus add 24'h000020 -> 24'h999999 (saturate).
- score=24'h000030, remove 24'h000040 -> 24'h000000; add and remove 24'h000010 pulsed same cycle from 24'h000050 -> add then sub, final 24'h000050.
- Three enableAddScore pulses 2 clks apart -> first runs, second pended, third dropped; scoreDropped=1; final score = start + 2*amount.
- lives=3: remove 1 three times -> lives 2,1,0; gameOver=1 on the third; a subsequent add-life is ignored; gameRestart -> lives=3, gameOver=0.
- requestTime len=60 -> bonusFramesLeft=60, decrements per startOfFrame; request len=10 at 50 left -> stays 50; request coincident with SOF -> no decrement; reaches 0 -> bonusActive=0.
